// File: rtl/node2noc_admission_ctrl_pkg.sv
// Shared widths and FSM encoding for the node2noc admission/retire controller.
// Field widths mirror the head-flit layout; the table depth matches the pending table.
package node2noc_admission_ctrl_pkg;

    localparam int N_BIT_SRC_HEAD_FLIT           = 4;
    localparam int N_BIT_DEST_HEAD_FLIT          = 4;
    localparam int N_BIT_CMD_HEAD_FLIT           = 3;
    localparam int TABLE_PENDING_NODE2NOC_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2
    } adm_state_e;

endpackage

// File: rtl/node2noc_admission_ctrl.sv
// Admission/retire controller in front of the node2noc pending-transaction table.
// Enforces one outstanding transaction per (sender, recipient) and tracks table occupancy.
module node2noc_admission_ctrl
    import node2noc_admission_ctrl_pkg::*;
#(
    parameter int TABLE_DEPTH    = TABLE_PENDING_NODE2NOC_WIDTH,
    parameter int N_BITS_POINTER = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid_i,
    input  logic [N_BIT_SRC_HEAD_FLIT-1:0]    req_sender_i,
    input  logic [N_BIT_DEST_HEAD_FLIT-1:0]   req_recipient_i,
    input  logic [N_BIT_CMD_HEAD_FLIT-1:0]    req_type_i,
    output logic                              req_ready_o,
    output logic                              hf_valid_o,
    output logic [N_BIT_SRC_HEAD_FLIT-1:0]    hf_sender_o,
    output logic [N_BIT_DEST_HEAD_FLIT-1:0]   hf_recipient_o,
    output logic [N_BIT_CMD_HEAD_FLIT-1:0]    hf_type_o,
    input  logic                              hf_ready_i,
    input  logic                              rsp_valid_i,
    input  logic [N_BIT_SRC_HEAD_FLIT-1:0]    rsp_sender_i,
    input  logic [N_BIT_DEST_HEAD_FLIT-1:0]   rsp_recipient_i,
    input  logic [N_BIT_CMD_HEAD_FLIT-1:0]    rsp_type_i,
    output logic                              rsp_ready_o,
    output logic                              new_pending_transaction_o,
    output logic [N_BIT_SRC_HEAD_FLIT-1:0]    new_sender_o,
    output logic [N_BIT_DEST_HEAD_FLIT-1:0]   new_recipient_o,
    output logic [N_BIT_CMD_HEAD_FLIT-1:0]    new_transaction_type_o,
    output logic                              query_o,
    output logic [N_BIT_SRC_HEAD_FLIT-1:0]    query_sender_o,
    output logic [N_BIT_DEST_HEAD_FLIT-1:0]   query_recipient_o,
    output logic [N_BIT_CMD_HEAD_FLIT-1:0]    query_transaction_type_o,
    output logic                              delete_transaction_o,
    input  logic                              is_a_pending_transaction_i,
    output logic [N_BITS_POINTER:0]           pending_count_o,
    output logic                              full_o,
    output logic                              blocked_o,
    output logic                              orphan_reply_o
);

    localparam logic [N_BITS_POINTER:0] DEPTH_C = TABLE_DEPTH[N_BITS_POINTER:0];
    localparam logic [N_BITS_POINTER:0] ONE_C   = {{N_BITS_POINTER{1'b0}}, 1'b1};

    adm_state_e                        state_q, state_d;
    logic [N_BIT_SRC_HEAD_FLIT-1:0]    sender_q, sender_d;
    logic [N_BIT_DEST_HEAD_FLIT-1:0]   recipient_q, recipient_d;
    logic [N_BIT_CMD_HEAD_FLIT-1:0]    type_q, type_d;
    logic [N_BITS_POINTER:0]           count_q, count_d;
    logic                              blocked_q, blocked_d;
    logic                              orphan_q, orphan_d;
    logic                              insert_s;
    logic                              retire_hit_s;
    logic                              full_s;

    assign full_s       = (count_q == DEPTH_C);
    assign retire_hit_s = rsp_valid_i & is_a_pending_transaction_i;

    // FSM next state, request capture and insert strobe
    always_comb begin
        state_d     = state_q;
        sender_d    = sender_q;
        recipient_d = recipient_q;
        type_d      = type_q;
        blocked_d   = 1'b0;
        insert_s    = 1'b0;
        req_ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    sender_d    = req_sender_i;
                    recipient_d = req_recipient_i;
                    type_d      = req_type_i;
                    state_d     = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // A reply owns the query port this cycle, so the request just waits.
                if (rsp_valid_i) begin
                    blocked_d = 1'b0;
                end else if (is_a_pending_transaction_i || full_s) begin
                    blocked_d = 1'b1;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (hf_ready_i) begin
                    insert_s = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Query port mux: retire has priority over the admission check
    always_comb begin
        query_o                  = 1'b0;
        delete_transaction_o     = 1'b0;
        query_sender_o           = sender_q;
        query_recipient_o        = recipient_q;
        query_transaction_type_o = type_q;
        if (rsp_valid_i) begin
            query_o                  = 1'b1;
            delete_transaction_o     = 1'b1;
            query_sender_o           = rsp_sender_i;
            query_recipient_o        = rsp_recipient_i;
            query_transaction_type_o = rsp_type_i;
        end else if (state_q == ST_CHECK) begin
            query_o = 1'b1;
        end else begin
            query_o = 1'b0;
        end
    end

    // Occupancy counter; insert and retire hit together cancel out
    always_comb begin
        count_d  = count_q;
        orphan_d = rsp_valid_i & ~is_a_pending_transaction_i;
        case ({insert_s, retire_hit_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // State, capture and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sender_q    <= '0;
            recipient_q <= '0;
            type_q      <= '0;
            count_q     <= '0;
            blocked_q   <= 1'b0;
            orphan_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sender_q    <= sender_d;
            recipient_q <= recipient_d;
            type_q      <= type_d;
            count_q     <= count_d;
            blocked_q   <= blocked_d;
            orphan_q    <= orphan_d;
        end
    end

    assign hf_valid_o                = (state_q == ST_ISSUE);
    assign hf_sender_o               = sender_q;
    assign hf_recipient_o            = recipient_q;
    assign hf_type_o                 = type_q;
    assign new_pending_transaction_o = insert_s;
    assign new_sender_o              = sender_q;
    assign new_recipient_o           = recipient_q;
    assign new_transaction_type_o    = type_q;
    assign rsp_ready_o               = 1'b1;
    assign pending_count_o           = count_q;
    assign full_o                    = full_s;
    assign blocked_o                 = blocked_q;
    assign orphan_reply_o            = orphan_q;

endmodule

// File: tb/tb_node2noc_admission_ctrl.sv
// Directed bench for node2noc_admission_ctrl with a behavioural pending table and a header scoreboard.
module tb_node2noc_admission_ctrl;
    import node2noc_admission_ctrl_pkg::*;

    localparam int SW = N_BIT_SRC_HEAD_FLIT;
    localparam int DW = N_BIT_DEST_HEAD_FLIT;
    localparam int CW = N_BIT_CMD_HEAD_FLIT;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [SW-1:0] s;
        logic [DW-1:0] r;
        logic [CW-1:0] t;
    } hdr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid_i = 1'b0;
    logic [SW-1:0] req_sender_i = '0;
    logic [DW-1:0] req_recipient_i = '0;
    logic [CW-1:0] req_type_i = '0;
    logic          req_ready_o;
    logic          hf_valid_o;
    logic [SW-1:0] hf_sender_o;
    logic [DW-1:0] hf_recipient_o;
    logic [CW-1:0] hf_type_o;
    logic          hf_ready_i = 1'b0;
    logic          rsp_valid_i = 1'b0;
    logic [SW-1:0] rsp_sender_i = '0;
    logic [DW-1:0] rsp_recipient_i = '0;
    logic [CW-1:0] rsp_type_i = '0;
    logic          rsp_ready_o;
    logic          new_pending_transaction_o;
    logic [SW-1:0] new_sender_o;
    logic [DW-1:0] new_recipient_o;
    logic [CW-1:0] new_transaction_type_o;
    logic          query_o;
    logic [SW-1:0] query_sender_o;
    logic [DW-1:0] query_recipient_o;
    logic [CW-1:0] query_transaction_type_o;
    logic          delete_transaction_o;
    logic          is_a_pending_transaction_i;
    logic [3:0]    pending_count_o;
    logic          full_o;
    logic          blocked_o;
    logic          orphan_reply_o;

    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;
    hdr_t exp_q[$];

    node2noc_admission_ctrl #(.TABLE_DEPTH(DEPTH), .N_BITS_POINTER(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_sender_i(req_sender_i),
        .req_recipient_i(req_recipient_i), .req_type_i(req_type_i),
        .req_ready_o(req_ready_o),
        .hf_valid_o(hf_valid_o), .hf_sender_o(hf_sender_o),
        .hf_recipient_o(hf_recipient_o), .hf_type_o(hf_type_o),
        .hf_ready_i(hf_ready_i),
        .rsp_valid_i(rsp_valid_i), .rsp_sender_i(rsp_sender_i),
        .rsp_recipient_i(rsp_recipient_i), .rsp_type_i(rsp_type_i),
        .rsp_ready_o(rsp_ready_o),
        .new_pending_transaction_o(new_pending_transaction_o),
        .new_sender_o(new_sender_o), .new_recipient_o(new_recipient_o),
        .new_transaction_type_o(new_transaction_type_o),
        .query_o(query_o), .query_sender_o(query_sender_o),
        .query_recipient_o(query_recipient_o),
        .query_transaction_type_o(query_transaction_type_o),
        .delete_transaction_o(delete_transaction_o),
        .is_a_pending_transaction_i(is_a_pending_transaction_i),
        .pending_count_o(pending_count_o), .full_o(full_o),
        .blocked_o(blocked_o), .orphan_reply_o(orphan_reply_o)
    );

    always #5 clk = ~clk;

    // Behavioural pending table: matches on sender/recipient only, synchronous reset
    logic          tv [DEPTH];
    logic [SW-1:0] ts [DEPTH];
    logic [DW-1:0] tr [DEPTH];
    logic          tbl_hit;
    int            hit_idx;
    int            free_idx;

    always_comb begin
        tbl_hit  = 1'b0;
        hit_idx  = 0;
        free_idx = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tv[i] && ts[i] == query_sender_o && tr[i] == query_recipient_o) begin
                tbl_hit = 1'b1;
                hit_idx = i;
            end
            if (!tv[i]) free_idx = i;
        end
    end

    assign is_a_pending_transaction_i = query_o & tbl_hit;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tv[i] <= 1'b0;
        end else begin
            if (delete_transaction_o && tbl_hit) tv[hit_idx] <= 1'b0;
            if (new_pending_transaction_o) begin
                tv[free_idx] <= 1'b1;
                ts[free_idx] <= new_sender_o;
                tr[free_idx] <= new_recipient_o;
            end
        end
    end

    function automatic logic model_has(input logic [SW-1:0] s, input logic [DW-1:0] r);
        logic f;
        f = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (tv[i] && ts[i] == s && tr[i] == r) f = 1'b1;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [SW-1:0] s, input logic [DW-1:0] r, input logic [CW-1:0] t);
        hdr_t h;
        int n;
        req_valid_i = 1'b1; req_sender_i = s; req_recipient_i = r; req_type_i = t;
        n = 0;
        while (!req_ready_o && n < 20) begin @(posedge clk); #1; n++; end
        chk("accept_ready", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        h.s = s; h.r = r; h.t = t;
        exp_q.push_back(h);
    endtask

    task automatic issue(input bit also_retire, input logic [SW-1:0] rs, input logic [DW-1:0] rr);
        hdr_t h;
        int n;
        n = 0;
        while (!hf_valid_o && n < 20) begin @(posedge clk); #1; n++; end
        chk("hf_valid", {31'd0, hf_valid_o}, 32'd1);
        if (exp_q.size() > 0) h = exp_q.pop_front();
        else h = '0;
        chk("hf_sender", {28'd0, hf_sender_o}, {28'd0, h.s});
        chk("hf_recipient", {28'd0, hf_recipient_o}, {28'd0, h.r});
        chk("hf_type", {29'd0, hf_type_o}, {29'd0, h.t});
        hf_ready_i = 1'b1;
        if (also_retire) begin
            rsp_valid_i = 1'b1; rsp_sender_i = rs; rsp_recipient_i = rr; rsp_type_i = 3'd0;
        end
        #1;
        chk("new_strobe", {31'd0, new_pending_transaction_o}, 32'd1);
        chk("new_sender", {28'd0, new_sender_o}, {28'd0, h.s});
        chk("new_recipient", {28'd0, new_recipient_o}, {28'd0, h.r});
        @(posedge clk); #1;
        hf_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        if (!also_retire) exp_count++;
        chk("count_after_issue", {28'd0, pending_count_o}, exp_count);
    endtask

    task automatic reply(input logic [SW-1:0] s, input logic [DW-1:0] r, input bit hit);
        rsp_valid_i = 1'b1; rsp_sender_i = s; rsp_recipient_i = r; rsp_type_i = 3'd5;
        #1;
        chk("rsp_query", {31'd0, query_o}, 32'd1);
        chk("rsp_delete", {31'd0, delete_transaction_o}, 32'd1);
        chk("rsp_query_sender", {28'd0, query_sender_o}, {28'd0, s});
        chk("rsp_query_recipient", {28'd0, query_recipient_o}, {28'd0, r});
        chk("rsp_ready", {31'd0, rsp_ready_o}, 32'd1);
        @(posedge clk); #1;
        rsp_valid_i = 1'b0;
        if (hit) exp_count--;
        chk("orphan_pulse", {31'd0, orphan_reply_o}, {31'd0, !hit});
        chk("count_after_reply", {28'd0, pending_count_o}, exp_count);
        chk("model_cleared", {31'd0, model_has(s, r)}, 32'd0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_hf_valid", {31'd0, hf_valid_o}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_count", {28'd0, pending_count_o}, 32'd0);
        chk("rst_blocked", {31'd0, blocked_o}, 32'd0);
        chk("rst_orphan", {31'd0, orphan_reply_o}, 32'd0);
        chk("rst_full", {31'd0, full_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single request: query at cycle 1, header at cycle 2
        accept(4'd1, 4'd4, 3'd2);
        chk("c1_query", {31'd0, query_o}, 32'd1);
        chk("c1_delete", {31'd0, delete_transaction_o}, 32'd0);
        chk("c1_query_sender", {28'd0, query_sender_o}, 32'd1);
        chk("c1_query_recipient", {28'd0, query_recipient_o}, 32'd4);
        chk("c1_query_type", {29'd0, query_transaction_type_o}, 32'd2);
        chk("c1_hf_valid", {31'd0, hf_valid_o}, 32'd0);
        @(posedge clk); #1;
        chk("c2_hf_valid", {31'd0, hf_valid_o}, 32'd1);
        chk("c2_req_ready", {31'd0, req_ready_o}, 32'd0);
        issue(1'b0, 4'd0, 4'd0);
        chk("model_has_1_4", {31'd0, model_has(4'd1, 4'd4)}, 32'd1);
        reply(4'd1, 4'd4, 1'b1);

        // Duplicate pair blocks until the pending one retires
        accept(4'd1, 4'd4, 3'd1);
        issue(1'b0, 4'd0, 4'd0);
        accept(4'd1, 4'd4, 3'd3);
        @(posedge clk); #1;
        chk("dup_blocked", {31'd0, blocked_o}, 32'd1);
        chk("dup_no_hf", {31'd0, hf_valid_o}, 32'd0);
        @(posedge clk); #1;
        chk("dup_blocked_held", {31'd0, blocked_o}, 32'd1);
        reply(4'd1, 4'd4, 1'b1);
        chk("dup_unblocked", {31'd0, blocked_o}, 32'd0);
        issue(1'b0, 4'd0, 4'd0);
        reply(4'd1, 4'd4, 1'b1);

        // Fill the table, ninth request waits for a retire
        for (int i = 0; i < DEPTH; i++) begin
            accept(SW'(i), DW'(15 - i), CW'(i));
            issue(1'b0, 4'd0, 4'd0);
        end
        chk("fill_full", {31'd0, full_o}, 32'd1);
        chk("fill_count", {28'd0, pending_count_o}, 32'd8);
        accept(4'd9, 4'd9, 3'd7);
        @(posedge clk); #1;
        chk("ninth_blocked", {31'd0, blocked_o}, 32'd1);
        chk("ninth_no_hf", {31'd0, hf_valid_o}, 32'd0);
        reply(4'd0, 4'd15, 1'b1);
        chk("fill_not_full", {31'd0, full_o}, 32'd0);
        issue(1'b0, 4'd0, 4'd0);
        chk("refill_full", {31'd0, full_o}, 32'd1);
        for (int i = 1; i < DEPTH; i++) reply(SW'(i), DW'(15 - i), 1'b1);
        reply(4'd9, 4'd9, 1'b1);

        // Insert and retire hit in the same cycle
        accept(4'd1, 4'd4, 3'd0);
        issue(1'b0, 4'd0, 4'd0);
        accept(4'd2, 4'd3, 3'd1);
        issue(1'b1, 4'd1, 4'd4);
        chk("sim_has_2_3", {31'd0, model_has(4'd2, 4'd3)}, 32'd1);
        chk("sim_no_1_4", {31'd0, model_has(4'd1, 4'd4)}, 32'd0);
        reply(4'd2, 4'd3, 1'b1);

        // Orphan reply on an empty table
        reply(4'd5, 4'd6, 1'b0);
        @(posedge clk); #1;
        chk("orphan_one_cycle", {31'd0, orphan_reply_o}, 32'd0);
        chk("orphan_count", {28'd0, pending_count_o}, 32'd0);

        // Reset while a header is waiting in ISSUE
        accept(4'd7, 4'd7, 3'd1);
        @(posedge clk); #1;
        chk("pre_rst_hf_valid", {31'd0, hf_valid_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hf_valid", {31'd0, hf_valid_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        exp_count = 0;
        @(posedge clk); #1;
        chk("post_rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("post_rst_count", {28'd0, pending_count_o}, 32'd0);
        chk("post_rst_hf_valid", {31'd0, hf_valid_o}, 32'd0);
        chk("post_rst_no_insert", {31'd0, model_has(4'd7, 4'd7)}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
